// File: rtl/md5_pkg.sv
// Shared constants and FSM encoding for the MD5 core scheduler.
package md5_pkg;

  localparam int unsigned BLOCK_W  = 512;
  localparam int unsigned DIGEST_W = 128;

  // MD5 initial chaining value, A in the top word down to D in the bottom word.
  localparam logic [DIGEST_W-1:0] MD5_IV = {32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476};

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StOut
  } sched_state_e;

endpackage

// File: rtl/md5_rr_arbiter.sv
// Round-robin grant select: first requester at or after the pointer wins (wrapping).
// The pointer moves to one past the finished owner when a message completes.
module md5_rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NumReq-1:0] req_i,
  input  logic              advance_i,
  input  logic [IdW-1:0]    advance_id_i,
  output logic [IdW-1:0]    owner_o,
  output logic              any_o
);

  logic [IdW-1:0]    ptr_q, ptr_d;
  logic [NumReq-1:0] rot;

  // Bit k of rot is the request of requester (ptr + k) mod NumReq.
  assign rot = NumReq'({req_i, req_i} >> ptr_q);

  // Pick the lowest set bit of the rotated vector and map it back to an id.
  always_comb begin
    owner_o = '0;
    any_o   = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      if (!any_o && rot[k]) begin
        any_o = 1'b1;
        if (32'(ptr_q) + k >= NumReq) begin
          owner_o = IdW'(32'(ptr_q) + k - NumReq);
        end else begin
          owner_o = IdW'(32'(ptr_q) + k);
        end
      end
    end
  end

  // Next pointer: one past the completing owner, wrapping at NumReq.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      if (advance_id_i == IdW'(NumReq - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = IdW'(32'(advance_id_i) + 1);
      end
    end
  end

  // Pointer register, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/md5_core_scheduler.sv
// Shares one MD5 block core among NUM_REQ requesters, one whole message at a time.
// Optional core watchdog enabled by defining MD5_SCHED_TIMEOUT_EN.
module md5_core_scheduler
  import md5_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned ID_W           = 2,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*BLOCK_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic                       core_enable,
  output logic [BLOCK_W-1:0]         core_data_in,
  output logic [31:0]                core_a,
  output logic [31:0]                core_b,
  output logic [31:0]                core_c,
  output logic [31:0]                core_d,
  input  logic [DIGEST_W-1:0]        core_hash,
  input  logic                       core_hash_ready,
  output logic                       digest_valid,
  input  logic                       digest_ready,
  output logic [DIGEST_W-1:0]        digest,
  output logic [ID_W-1:0]            digest_id,
  output logic                       digest_error
);

  sched_state_e         state_q, state_d;
  logic [ID_W-1:0]      owner_q, owner_d, grant;
  logic                 any_req, advance, last_q, last_d, core_enable_q, core_enable_d;
  logic [BLOCK_W-1:0]   data_q, data_d, sel_data;
  logic                 sel_valid, sel_last, err_w;
  logic [DIGEST_W-1:0]  chain_q, chain_d, abcd_q, abcd_d;

`ifdef MD5_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  assign err_w = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign err_w = 1'b0;
`endif

  md5_rr_arbiter #(
    .NumReq(NUM_REQ),
    .IdW   (ID_W)
  ) u_arb (
    .clk_i       (clk),
    .rst_ni      (reset),
    .req_i       (req_valid),
    .advance_i   (advance),
    .advance_id_i(owner_q),
    .owner_o     (grant),
    .any_o       (any_req)
  );

  // Owner's request mux; ready depends only on state and owner, never on valid.
  always_comb begin
    req_ready = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (owner_q == ID_W'(i)) begin
        sel_data     = req_data[i*BLOCK_W +: BLOCK_W];
        sel_valid    = req_valid[i];
        sel_last     = req_last[i];
        req_ready[i] = (state_q == StIssue);
      end
    end
  end

  // Next-state logic for the message sequencer.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    data_d        = data_q;
    chain_d       = chain_q;
    abcd_d        = abcd_q;
    core_enable_d = 1'b0;
    advance       = 1'b0;
`ifdef MD5_SCHED_TIMEOUT_EN
    cnt_d = cnt_q;
    err_d = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          owner_d = grant;
          chain_d = MD5_IV;
          state_d = StIssue;
`ifdef MD5_SCHED_TIMEOUT_EN
          err_d = 1'b0;
`endif
        end
      end
      StIssue: begin
        if (sel_valid) begin
          data_d        = sel_data;
          last_d        = sel_last;
          abcd_d        = chain_q;
          core_enable_d = 1'b1;
          state_d       = StWait;
`ifdef MD5_SCHED_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      StWait: begin
        if (core_hash_ready) begin
          chain_d = core_hash;
          state_d = last_q ? StOut : StIssue;
        end
`ifdef MD5_SCHED_TIMEOUT_EN
        // cnt_q is 0 in the core_enable cycle, so this fires TIMEOUT_CYCLES cycles later.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = StOut;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      StOut: begin
        if (digest_ready) begin
          advance = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers, synchronous active-low reset; a reset discards any message in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      owner_q       <= '0;
      last_q        <= 1'b0;
      data_q        <= '0;
      chain_q       <= MD5_IV;
      abcd_q        <= '0;
      core_enable_q <= 1'b0;
`ifdef MD5_SCHED_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      data_q        <= data_d;
      chain_q       <= chain_d;
      abcd_q        <= abcd_d;
      core_enable_q <= core_enable_d;
`ifdef MD5_SCHED_TIMEOUT_EN
      cnt_q <= cnt_d;
      err_q <= err_d;
`endif
    end
  end

  assign core_enable  = core_enable_q;
  assign core_data_in = data_q;
  assign core_a       = abcd_q[127:96];
  assign core_b       = abcd_q[95:64];
  assign core_c       = abcd_q[63:32];
  assign core_d       = abcd_q[31:0];

  // Digest is gated so it reads 0 outside OUT and on a watchdog abort.
  assign digest_valid = (state_q == StOut);
  assign digest_error = digest_valid & err_w;
  assign digest       = (digest_valid && !err_w) ? chain_q : '0;
  assign digest_id    = owner_q;

endmodule
